// File: rtl/tnn_output_packer_if.sv
// Byte-in / word-out bus of the ternary output packer.
// The master drives bytes and ready; the slave returns packed words.
interface tnn_output_packer_if #(
  parameter int BYTE_WIDTH = 8
);
  logic [BYTE_WIDTH-1:0] data_i;
  logic                  valid_i;
  logic                  flush_i;
  logic                  clear_i;
  logic                  ready_i;
  logic [31:0]           word_o;
  logic [3:0]            byte_en_o;
  logic                  valid_o;
  logic                  overflow_o;
  logic                  busy_o;

  modport master (
    output data_i,
    output valid_i,
    output flush_i,
    output clear_i,
    output ready_i,
    input  word_o,
    input  byte_en_o,
    input  valid_o,
    input  overflow_o,
    input  busy_o
  );

  modport slave (
    input  data_i,
    input  valid_i,
    input  flush_i,
    input  clear_i,
    input  ready_i,
    output word_o,
    output byte_en_o,
    output valid_o,
    output overflow_o,
    output busy_o
  );
endinterface

// File: rtl/tnn_output_packer.sv
// Packs compressed activation bytes little-endian into 32-bit words
// and queues them in a small FIFO, with a one-word pending slot.
module tnn_output_packer #(
  parameter int BYTE_WIDTH = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  tnn_output_packer_if.slave bus
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]     mem_word [FIFO_DEPTH];
  logic [3:0]      mem_be   [FIFO_DEPTH];
  logic [PW-1:0]   rd_q;
  logic [PW-1:0]   wr_q;
  logic [CW-1:0]   num_q;

  // While pend_q is set, asm_q/cnt_q hold a closed word awaiting space.
  logic [31:0]     asm_q;
  logic [2:0]      cnt_q;
  logic            pend_q;
  logic            ovf_q;

  logic [BYTE_WIDTH-1:0] data;
  logic [7:0]      lane;
  logic            pop;
  logic            full;
  logic            room;
  logic            close;
  logic            push;
  logic            drop;
  logic [31:0]     nxt_asm;
  logic [2:0]      nxt_cnt;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(FIFO_DEPTH - 1))
      ? '0 : p + PW'(1);
  endfunction

  function automatic logic [3:0] be_of(
    input logic [2:0] n
  );
    logic [3:0] be;
    unique case (n)
      3'd1:    be = 4'b0001;
      3'd2:    be = 4'b0011;
      3'd3:    be = 4'b0111;
      3'd4:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  assign data = bus.data_i;
  assign lane = 8'(data);
  assign pop  = (num_q != '0) && bus.ready_i;
  assign full = (num_q == CW'(FIFO_DEPTH));
  assign room = !full || pop;

  always_comb begin
    drop    = 1'b0;
    close   = 1'b0;
    nxt_asm = asm_q;
    nxt_cnt = cnt_q;
    if (pend_q) begin
      drop  = bus.valid_i;
      close = 1'b1;
    end else begin
      if (bus.valid_i) begin
        nxt_asm = asm_q
          | ({24'b0, lane} << {cnt_q[1:0], 3'b000});
        nxt_cnt = cnt_q + 3'd1;
      end
      close = (nxt_cnt == 3'd4)
           || (bus.flush_i && nxt_cnt != 3'd0);
    end
  end

  assign push = close && room;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      asm_q  <= '0;
      cnt_q  <= '0;
      pend_q <= 1'b0;
      ovf_q  <= 1'b0;
      rd_q   <= '0;
      wr_q   <= '0;
      num_q  <= '0;
    end else if (bus.clear_i) begin
      asm_q  <= '0;
      cnt_q  <= '0;
      pend_q <= 1'b0;
      ovf_q  <= 1'b0;
      rd_q   <= '0;
      wr_q   <= '0;
      num_q  <= '0;
    end else begin
      if (push) begin
        asm_q  <= '0;
        cnt_q  <= '0;
        pend_q <= 1'b0;
      end else begin
        asm_q  <= nxt_asm;
        cnt_q  <= nxt_cnt;
        pend_q <= close;
      end
      if (drop) ovf_q <= 1'b1;
      if (push) wr_q <= inc(wr_q);
      if (pop)  rd_q <= inc(rd_q);
      if (push && !pop)
        num_q <= num_q + CW'(1);
      else if (pop && !push)
        num_q <= num_q - CW'(1);
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push && !bus.clear_i) begin
      mem_word[wr_q] <= nxt_asm;
      mem_be[wr_q]   <= be_of(nxt_cnt);
    end
  end

  assign bus.valid_o    = (num_q != '0);
  assign bus.word_o     = bus.valid_o ? mem_word[rd_q] : '0;
  assign bus.byte_en_o  = bus.valid_o ? mem_be[rd_q] : '0;
  assign bus.overflow_o = ovf_q;
  assign bus.busy_o     = (cnt_q != 3'd0) || pend_q
                       || (num_q != '0);

endmodule

// File: tb/tb_tnn_output_packer.sv
// Directed checks of tnn_output_packer against hand-computed words.
module tb_tnn_output_packer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  tnn_output_packer_if #(.BYTE_WIDTH(8)) bus ();

  tnn_output_packer #(
    .BYTE_WIDTH(8),
    .FIFO_DEPTH(2)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic put(input logic [7:0] b);
    bus.valid_i = 1'b1;
    bus.data_i  = b;
    tick();
    bus.valid_i = 1'b0;
  endtask

  initial begin
    bus.data_i  = '0;
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.clear_i = 1'b0;
    bus.ready_i = 1'b1;
    tick();
    tick();
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_word", bus.word_o, 0);
    chk("rst_be", bus.byte_en_o, 0);
    chk("rst_ovf", bus.overflow_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    rst_n = 1'b1;
    tick();

    // full word
    put(8'h11);
    put(8'h22);
    chk("w1_busy_mid", bus.busy_o, 1);
    chk("w1_valid_mid", bus.valid_o, 0);
    put(8'h33);
    put(8'h44);
    chk("w1_valid", bus.valid_o, 1);
    chk("w1_word", bus.word_o, 32'h44332211);
    chk("w1_be", bus.byte_en_o, 4'b1111);
    tick();
    chk("w1_gone", bus.valid_o, 0);
    chk("w1_idle", bus.busy_o, 0);

    // flush of a partial word
    put(8'hA1);
    put(8'hB2);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    chk("w2_valid", bus.valid_o, 1);
    chk("w2_word", bus.word_o, 32'h0000B2A1);
    chk("w2_be", bus.byte_en_o, 4'b0011);
    tick();
    chk("w2_gone", bus.valid_o, 0);

    // byte and flush in the same cycle
    put(8'h10);
    put(8'h20);
    bus.flush_i = 1'b1;
    put(8'h7F);
    bus.flush_i = 1'b0;
    chk("w3_word", bus.word_o, 32'h007F2010);
    chk("w3_be", bus.byte_en_o, 4'b0111);
    tick();

    // empty flush has no effect
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    chk("ef_valid", bus.valid_o, 0);
    chk("ef_busy", bus.busy_o, 0);

    // backpressure: two words in FIFO, third pending
    bus.ready_i = 1'b0;
    for (int i = 1; i <= 12; i++) put(8'(i));
    chk("bp_valid", bus.valid_o, 1);
    chk("bp_head1", bus.word_o, 32'h04030201);
    chk("bp_ovf", bus.overflow_o, 0);
    chk("bp_busy", bus.busy_o, 1);
    tick();
    chk("bp_hold", bus.word_o, 32'h04030201);
    bus.ready_i = 1'b1;
    tick();
    chk("bp_head2", bus.word_o, 32'h08070605);
    tick();
    chk("bp_head3", bus.word_o, 32'h0C0B0A09);
    chk("bp_be3", bus.byte_en_o, 4'b1111);
    tick();
    chk("bp_empty", bus.valid_o, 0);
    chk("bp_idle", bus.busy_o, 0);
    chk("bp_ovf2", bus.overflow_o, 0);

    // overflow: 13th byte dropped
    bus.ready_i = 1'b0;
    for (int i = 1; i <= 13; i++) put(8'(i));
    chk("of_set", bus.overflow_o, 1);
    chk("of_head", bus.word_o, 32'h04030201);
    bus.ready_i = 1'b1;
    tick();
    chk("of_head2", bus.word_o, 32'h08070605);
    tick();
    chk("of_head3", bus.word_o, 32'h0C0B0A09);
    tick();
    chk("of_empty", bus.valid_o, 0);
    chk("of_idle", bus.busy_o, 0);
    chk("of_sticky", bus.overflow_o, 1);
    bus.clear_i = 1'b1;
    tick();
    bus.clear_i = 1'b0;
    chk("of_clr", bus.overflow_o, 0);
    bus.flush_i = 1'b1;
    put(8'h55);
    bus.flush_i = 1'b0;
    chk("of_55", bus.word_o, 32'h00000055);
    chk("of_55be", bus.byte_en_o, 4'b0001);
    tick();

    // clear beats a same-cycle byte
    put(8'hAA);
    bus.clear_i = 1'b1;
    put(8'hBB);
    bus.clear_i = 1'b0;
    chk("cl_busy", bus.busy_o, 0);
    for (int i = 1; i <= 4; i++) put(8'(i));
    chk("cl_word", bus.word_o, 32'h04030201);
    tick();

    // async reset mid-word with FIFO contents
    bus.ready_i = 1'b0;
    for (int i = 1; i <= 6; i++) put(8'(i));
    chk("ar_pre", bus.valid_o, 1);
    rst_n = 1'b0;
    #1;
    chk("ar_valid", bus.valid_o, 0);
    chk("ar_busy", bus.busy_o, 0);
    chk("ar_word", bus.word_o, 0);
    #2;
    rst_n = 1'b1;
    bus.ready_i = 1'b1;
    tick();
    chk("ar_nowd", bus.valid_o, 0);
    for (int i = 1; i <= 4; i++) put(8'(i));
    chk("ar_word2", bus.word_o, 32'h04030201);
    chk("ar_be2", bus.byte_en_o, 4'b1111);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end
endmodule

// File: doc/tnn_output_packer.md
TNN_OUTPUT_PACKER -- requirements
Module: tnn_output_packer

Interface
REQ-001 Parameter BYTE_WIDTH, default 8, width of one compressed activation byte (5 trits).
REQ-002 Parameter FIFO_DEPTH, default 2, number of 32-bit output word entries.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_ni  input  1  asynchronous, active-low reset.
REQ-005 data_i  input  BYTE_WIDTH  compressed byte from the thresholding stage.
REQ-006 valid_i  input  1  single-cycle strobe, data_i valid; upstream cannot stall.
REQ-007 flush_i  input  1  close the current partial word (end of output row).
REQ-008 clear_i  input  1  synchronous clear of all state, including overflow_o.
REQ-009 word_o  output  32  packed word at FIFO head.
REQ-010 byte_en_o  output  4  byte enables of word_o; bit k covers word_o[8k+7:8k].
REQ-011 valid_o  output  1  FIFO head valid.
REQ-012 ready_i  input  1  consumer accepts head; pop when valid_o && ready_i.
REQ-013 overflow_o  output  1  sticky: at least one byte was dropped.
REQ-014 busy_o  output  1  high when assembly register, pending word or FIFO is non-empty.

Function
REQ-015 Bytes shall pack little-endian: first byte after a word boundary to [7:0], fourth to [31:24].
REQ-016 Byte count cnt (0..4) shall increment on each accepted valid_i.
REQ-017 A word shall close when cnt reaches 4, or on flush_i with cnt>0 after including any same-cycle accepted byte.
REQ-018 A closed word shall push to the FIFO on the closing edge if FIFO not full or a pop occurs that cycle; cnt then returns to 0.
REQ-019 If the push cannot occur, the word shall stay pending and retry every cycle; push occurs on the first cycle with space.
REQ-020 valid_i while a pending (unpushed, closed in an earlier cycle) word exists: byte dropped, overflow_o set next edge, pending word unchanged.
REQ-021 flush_i with cnt==0, no valid_i, no pending word: no effect.
REQ-022 flush_i while a word is already pending: ignored (pending word already closed).
REQ-023 Full words: byte_en_o=4'b1111; partial words: byte_en_o low bits set for cnt bytes, unused bytes of word_o zero.
REQ-024 Latency: valid_o shall rise the cycle after the push edge; word_o/byte_en_o stable while valid_o && !ready_i.
REQ-025 FIFO order shall be strict FIFO; simultaneous push and pop at full shall both succeed.
REQ-026 clear_i shall take priority over valid_i, flush_i and pop in the same cycle.
REQ-027 busy_o shall be combinational from registered state only.

Reset
REQ-028 On rst_ni low, asynchronously: cnt=0, assembly register=0, no pending word, FIFO empty, valid_o=0, word_o=0, byte_en_o=0, overflow_o=0, busy_o=0.
REQ-029 Reset asserted mid-word or with pending/FIFO contents shall discard all data without emitting a word.
REQ-030 clear_i shall produce the same state as reset on the next edge.

Verification
REQ-031 ready_i=1; bytes 0x11,0x22,0x33,0x44 on consecutive cycles -> one cycle later word_o=0x44332211, byte_en_o=1111, valid_o=1 for one cycle.
REQ-032 ready_i=1; bytes 0xA1,0xB2 then flush_i -> word_o=0x0000B2A1, byte_en_o=0011.
REQ-033 ready_i=0; 12 bytes 0x01..0x0C -> FIFO holds 0x04030201, 0x08070605; third word pending, no overflow; raise ready_i -> three words in order, overflow_o=0.
REQ-034 ready_i=0; 13 bytes -> 13th byte dropped, overflow_o=1 and stays 1 after drain until clear_i; a later byte (0x55) after clear_i lands in [7:0] of the next word.
REQ-035 valid_i=0x7F with flush_i same cycle, cnt=2 (0x10,0x20) -> word_o=0x007F2010, byte_en_o=0111.
REQ-036 rst_ni pulsed low after 2 bytes and with one word in FIFO -> valid_o=0 and busy_o=0 immediately; next 4 bytes 0x01..0x04 -> word_o=0x04030201.
